// File: rtl/shared_pkg.sv
// Shared UART definitions: data width, receive-controller state enum and
// status counter width.
package shared_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ERR_CNT_W  = 8;

  // Prefixed names keep these apart from the receiver's own state enum.
  typedef enum logic [1:0] {
    CTRL_OFF   = 2'd0,
    CTRL_RUN   = 2'd1,
    CTRL_FLUSH = 2'd2
  } uart_rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous clear.
// Contract: push while full only together with pop; pop only while non-empty.
module sync_fifo #(
  parameter int  WIDTH = 9,
  parameter int  DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; the head is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: tags received bytes with pending errors, buffers
// them in a FIFO, and keeps overrun/error-count/threshold/timeout status.
module uart_rx_ctrl
  import shared_pkg::*;
#(
  parameter int  FIFO_DEPTH     = 8,
  parameter int  THRESHOLD      = 4,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int CW             = $clog2(FIFO_DEPTH + 1),
  localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  irq_clr,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  rx_error,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  overrun,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  thresh_irq,
  output logic                  timeout_irq,
  output uart_rx_ctrl_state_e   state_dbg
);

  uart_rx_ctrl_state_e state_q, state_d;
  logic                 err_pend_q, err_pend_d;
  logic                 overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 thresh_q, thresh_d;
  logic                 timeout_q, timeout_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;

  logic                  in_run, in_flush;
  logic                  push, pop, push_req, drop, full, tag, run_idle, tmo_fire;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (in_flush),
    .push  (push),
    .pop   (pop),
    .wdata ({tag, rx_data}),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  // Stream handshake: out_valid/out_data/out_err are stable while out_valid=1
  // and out_ready=0; a transfer happens in every cycle with out_valid & out_ready.
  always_comb begin
    in_run    = (state_q == CTRL_RUN);
    in_flush  = (state_q == CTRL_FLUSH);
    full      = (fifo_count == CW'(FIFO_DEPTH));
    out_valid = (fifo_count != '0) && !in_flush;
    pop       = out_valid && out_ready;
    push_req  = in_run && rx_done;
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    tag       = err_pend_q | rx_error;
    out_data  = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    out_err   = out_valid ? fifo_head[DATA_WIDTH] : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = CTRL_FLUSH;
    end else begin
      case (state_q)
        CTRL_OFF:   state_d = en ? CTRL_RUN : CTRL_OFF;
        CTRL_RUN:   state_d = en ? CTRL_RUN : CTRL_OFF;
        CTRL_FLUSH: state_d = en ? CTRL_RUN : CTRL_OFF;
        default:    state_d = CTRL_OFF;
      endcase
    end
  end

  always_comb begin
    err_pend_d = err_pend_q;
    if (!in_run || push) err_pend_d = 1'b0;
    else if (rx_error)   err_pend_d = 1'b1;

    err_cnt_d = irq_clr ? '0 : err_cnt_q;
    if (push && tag && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);

    overrun_d = drop | (overrun_q & ~irq_clr);
    thresh_d  = (fifo_count >= CW'(THRESHOLD));

    // Counter holds at its terminal value, so the flag fires only on arrival.
    run_idle  = in_run && (fifo_count != '0) && !push && !pop;
    tmo_cnt_d = '0;
    tmo_fire  = 1'b0;
    if (run_idle) begin
      if (tmo_cnt_q != TW'(TIMEOUT_CYCLES - 1)) tmo_cnt_d = tmo_cnt_q + TW'(1);
      else                                      tmo_cnt_d = tmo_cnt_q;
      tmo_fire = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 2));
    end
    timeout_d = tmo_fire | (timeout_q & ~irq_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CTRL_OFF;
      err_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
      thresh_q   <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_pend_q <= err_pend_d;
      overrun_q  <= overrun_d;
      err_cnt_q  <= err_cnt_d;
      thresh_q   <= thresh_d;
      timeout_q  <= timeout_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign count       = fifo_count;
  assign overrun     = overrun_q;
  assign err_cnt     = err_cnt_q;
  assign thresh_irq  = thresh_q;
  assign timeout_irq = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;
  import shared_pkg::*;

  localparam int D  = 8;
  localparam int TH = 4;
  localparam int TC = 64;
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(D + 1);

  logic                 clk, rst, en, flush, irq_clr, rx_done, rx_error, out_ready;
  logic [W-1:0]         rx_data, out_data;
  logic                 out_err, out_valid, overrun, thresh_irq, timeout_irq;
  logic [CW-1:0]        count;
  logic [ERR_CNT_W-1:0] err_cnt;
  uart_rx_ctrl_state_e  state_dbg;

  uart_rx_ctrl #(.FIFO_DEPTH(D), .THRESHOLD(TH), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .irq_clr(irq_clr),
    .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overrun(overrun), .err_cnt(err_cnt),
    .thresh_irq(thresh_irq), .timeout_irq(timeout_irq), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural model: mode 0=off 1=run 2=flush; exp_q holds {tag, byte}
  logic [W:0] exp_q[$];
  int m_mode, m_ecnt, m_idle;
  bit m_pend, m_ovr, m_thr, m_tmo;

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_ecnt = 0; m_idle = 0;
    m_pend = 0; m_ovr = 0; m_thr = 0; m_tmo = 0;
  endtask

  task automatic check_outputs();
    bit v;
    logic [W:0] head;
    v    = (exp_q.size() != 0) && (m_mode != 2);
    head = v ? exp_q[0] : '0;
    check("count",       32'(count),       32'(exp_q.size()));
    check("out_valid",   32'(out_valid),   32'(v));
    check("out_data",    32'(out_data),    32'(head[W-1:0]));
    check("out_err",     32'(out_err),     32'(head[W]));
    check("overrun",     32'(overrun),     32'(m_ovr));
    check("err_cnt",     32'(err_cnt),     32'(m_ecnt));
    check("thresh_irq",  32'(thresh_irq),  32'(m_thr));
    check("timeout_irq", 32'(timeout_irq), 32'(m_tmo));
  endtask

  // driver: check current outputs, apply one cycle of inputs, advance model
  task automatic cyc(input bit i_en, input bit i_flush, input bit i_clr, input bit i_done,
                     input bit i_err, input bit i_ready, input logic [W-1:0] i_data);
    int sz;
    bit v, pop, preq, tag, acc, drop, fire;
    check_outputs();
    en = i_en; flush = i_flush; irq_clr = i_clr; rx_done = i_done;
    rx_error = i_err; out_ready = i_ready; rx_data = i_data;
    sz   = exp_q.size();
    v    = (sz != 0) && (m_mode != 2);
    pop  = v && i_ready;
    preq = (m_mode == 1) && i_done;
    tag  = m_pend | i_err;
    acc  = 0; drop = 0; fire = 0;
    m_thr = (sz >= TH);
    if (m_mode == 2) exp_q.delete();
    else begin
      acc  = preq && ((sz < D) || pop);
      drop = preq && !acc;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({tag, i_data});
    end
    if (i_clr) m_ecnt = 0;
    if (acc && tag && m_ecnt < 255) m_ecnt++;
    if (i_clr) m_ovr = 0;
    if (drop) m_ovr = 1;
    if (m_mode != 1 || acc) m_pend = 0;
    else if (i_err) m_pend = 1;
    if (m_mode == 1 && sz != 0 && !acc && !pop) begin
      if (m_idle < TC - 1) begin
        m_idle++;
        if (m_idle == TC - 1) fire = 1;
      end
    end else m_idle = 0;
    if (i_clr) m_tmo = 0;
    if (fire) m_tmo = 1;
    m_mode = i_flush ? 2 : (i_en ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [W-1:0] d, input bit ready);
    cyc(1, 0, 0, 1, 0, ready, d);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, ready, '0);
  endtask

  initial begin
    rst = 1; en = 0; flush = 0; irq_clr = 0; rx_done = 0; rx_error = 0;
    out_ready = 0; rx_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 0;

    // pass-through
    idle(1, 1);
    push_byte(8'hA5, 1);
    idle(3, 1);

    // error tagging with a gap, then a clean byte
    cyc(1, 0, 0, 0, 1, 0, '0);
    idle(3, 0);
    push_byte(8'h3C, 0);
    idle(2, 0);
    idle(2, 1);
    push_byte(8'h11, 0);
    idle(2, 1);

    // fill past full, then push+pop while full
    for (int i = 0; i < 9; i++) push_byte(W'($urandom_range(0, 255)), 0);
    idle(1, 0);
    push_byte(8'h77, 1);
    idle(1, 0);
    idle(10, 1);

    // threshold then idle timeout, clear, no re-fire until traffic
    cyc(1, 0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) push_byte(W'($urandom_range(0, 255)), 0);
    idle(70, 0);
    cyc(1, 0, 1, 0, 0, 0, '0);
    idle(70, 0);
    idle(1, 1);
    idle(70, 0);
    idle(6, 1);

    // flush with simultaneous rx_done, then disabled pushes
    for (int i = 0; i < 3; i++) push_byte(W'($urandom_range(0, 255)), 0);
    cyc(1, 1, 0, 1, 0, 0, 8'h5A);
    idle(2, 0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 1, 0, 8'h99);
    cyc(0, 0, 0, 1, 0, 0, 8'h98);

    // async reset mid-operation with count=5 and overrun set
    idle(1, 0);
    for (int i = 0; i < 9; i++) push_byte(W'($urandom_range(0, 255)), 0);
    idle(3, 1);
    check_outputs();
    #2 rst = 1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst = 0;
    idle(1, 0);
    push_byte(8'hC3, 0);
    idle(2, 0);
    idle(10, 1);

    // err_cnt saturation: continuous tagged traffic
    for (int i = 0; i < 300; i++) cyc(1, 0, 0, 1, 1, 1, W'($urandom_range(0, 255)));
    idle(4, 1);

    // randomized phases
    for (int ph = 0; ph < 15; ph++) begin
      int p_ready, p_done, p_err;
      p_ready = $urandom_range(0, 3) * 33;
      p_done  = $urandom_range(10, 90);
      p_err   = $urandom_range(0, 30);
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 99) < 95,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < p_done,
            $urandom_range(0, 99) < p_err,
            $urandom_range(0, 99) < p_ready,
            W'($urandom_range(0, 255)));
      end
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
